aurora_rx_nfc_buf: RTL and testbench

Receive-side elastic buffer with Aurora native flow control (NFC) generation, placed between an Aurora 64B/66B core's AXI-stream RX output and the router-facing receive path, in the `AURORA_CLK` domain. The Aurora RX stream cannot be stalled, so this block stores incoming words and holds the far end off before the buffer overflows.
- Fill crosses the high watermark → XOFF sent on the core's NFC channel.
- Fill drains to the low watermark → XON sent.
- Buffered words are presented downstream with router-style backpressure.

---
 rtl/aurora_nfc_pkg.sv | 16 +
 rtl/sync_fifo_bram.sv | 54 +++++
 rtl/aurora_rx_nfc_buf.sv | 127 ++++++++++++
 tb/tb_aurora_rx_nfc_buf.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_nfc_pkg.sv
// Shared types and constants for the Aurora RX elastic buffer and its NFC generator.
package aurora_nfc_pkg;

    localparam int AURORA_DW = 64;

    localparam logic [15:0] NFC_XOFF_CODE = 16'h0100;
    localparam logic [15:0] NFC_XON_CODE  = 16'h0000;

    typedef enum logic [1:0] {
        XON_IDLE  = 2'd0,
        SEND_XOFF = 2'd1,
        XOFF_HELD = 2'd2,
        SEND_XON  = 2'd3
    } nfc_state_e;

endpackage

// File: rtl/sync_fifo_bram.sv
// Single-clock FIFO on a block RAM with a registered read port and an occupancy count.
// A read and write to the same address in one cycle returns the old contents.
module sync_fifo_bram #(
    parameter int AW = 9,
    parameter int DW = 65
) (
    input  logic          CLK,
    input  logic          SYS_RST,
    input  logic          i_flush,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic [AW:0]   o_count
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [DW-1:0] r_rd_data;
    logic [AW:0]   r_count;

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (SYS_RST || i_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
            r_count   <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;

endmodule

// File: rtl/aurora_rx_nfc_buf.sv
// Elastic buffer behind the unstallable Aurora RX stream; throttles the link partner
// with NFC XOFF/XON around high/low watermarks and serves words with backpressure.
module aurora_rx_nfc_buf
    import aurora_nfc_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 9,
    parameter int          HI_WM      = 448,
    parameter int          LO_WM      = 128,
    parameter logic [15:0] NFC_XOFF   = NFC_XOFF_CODE,
    parameter logic [15:0] NFC_XON    = NFC_XON_CODE
) (
    input  logic                  CLK,
    input  logic                  SYS_RST,
    input  logic                  CH_UP,
    input  logic [AURORA_DW-1:0]  RX_TDATA,
    input  logic                  RX_TVALID,
    input  logic                  RX_TLAST,
    output logic [AURORA_DW-1:0]  Q,
    output logic                  Q_LAST,
    output logic                  Q_VALID,
    input  logic                  Q_BP,
    output logic                  NFC_TVALID,
    output logic [15:0]           NFC_TDATA,
    input  logic                  NFC_TREADY,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  OVERFLOW,
    output nfc_state_e            NFC_STATE
);

    localparam logic [DEPTH_LOG2:0] L_DEPTH = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] L_HI    = (DEPTH_LOG2+1)'(HI_WM);
    localparam logic [DEPTH_LOG2:0] L_LO    = (DEPTH_LOG2+1)'(LO_WM);

    logic [DEPTH_LOG2:0] w_level;
    logic [AURORA_DW:0]  w_rd_data;
    logic                w_pop;
    logic                w_wr;
    logic                r_q_valid;
    logic                r_overflow;
    logic [15:0]         r_last_code;
    nfc_state_e          r_state;
    nfc_state_e          w_state_nxt;

    // The RAM read register doubles as the output register: it only loads on a pop,
    // so Q holds while downstream applies backpressure.
    assign w_pop = CH_UP && (w_level != '0) && (!r_q_valid || !Q_BP);
    assign w_wr  = CH_UP && RX_TVALID && ((w_level != L_DEPTH) || w_pop);

    sync_fifo_bram #(
        .AW (DEPTH_LOG2),
        .DW (AURORA_DW + 1)
    ) u_fifo (
        .CLK       (CLK),
        .SYS_RST   (SYS_RST),
        .i_flush   (!CH_UP),
        .i_wr_en   (w_wr),
        .i_wr_data ({RX_TLAST, RX_TDATA}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_count   (w_level)
    );

    always_ff @(posedge CLK) begin
        if (SYS_RST || !CH_UP) begin
            r_q_valid <= 1'b0;
        end else if (w_pop) begin
            r_q_valid <= 1'b1;
        end else if (!Q_BP) begin
            r_q_valid <= 1'b0;
        end
    end

    // Sticky across channel-down; only reset clears it.
    always_ff @(posedge CLK) begin
        if (SYS_RST) begin
            r_overflow <= 1'b0;
        end else if (CH_UP && RX_TVALID && !w_wr) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (SYS_RST) begin
            r_state     <= XON_IDLE;
            r_last_code <= NFC_XON;
        end else begin
            r_state <= w_state_nxt;
            if (CH_UP && NFC_TVALID && NFC_TREADY) begin
                r_last_code <= NFC_TDATA;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        NFC_TVALID  = 1'b0;
        NFC_TDATA   = r_last_code;
        case (r_state)
            XON_IDLE: begin
                if (w_level >= L_HI) w_state_nxt = SEND_XOFF;
            end
            SEND_XOFF: begin
                NFC_TVALID = 1'b1;
                NFC_TDATA  = NFC_XOFF;
                if (NFC_TREADY) w_state_nxt = XOFF_HELD;
            end
            XOFF_HELD: begin
                if (w_level <= L_LO) w_state_nxt = SEND_XON;
            end
            SEND_XON: begin
                NFC_TVALID = 1'b1;
                NFC_TDATA  = NFC_XON;
                if (NFC_TREADY) w_state_nxt = (w_level >= L_HI) ? SEND_XOFF : XON_IDLE;
            end
            default: w_state_nxt = XON_IDLE;
        endcase
        if (!CH_UP) w_state_nxt = XON_IDLE;
    end

    assign Q         = w_rd_data[AURORA_DW-1:0];
    assign Q_LAST    = w_rd_data[AURORA_DW];
    assign Q_VALID   = r_q_valid;
    assign LEVEL     = w_level;
    assign OVERFLOW  = r_overflow;
    assign NFC_STATE = r_state;

endmodule

// File: tb/tb_aurora_rx_nfc_buf.sv
// Bench for aurora_rx_nfc_buf: table-driven streaming, NFC watermarks, overflow,
// channel-down flush and mid-stream reset, with a queue scoreboard on the Q port.
module tb_aurora_rx_nfc_buf;
    import aurora_nfc_pkg::*;

    logic        CLK = 1'b0;
    logic        SYS_RST;
    logic        CH_UP;
    logic [63:0] RX_TDATA;
    logic        RX_TVALID;
    logic        RX_TLAST;
    logic [63:0] Q;
    logic        Q_LAST;
    logic        Q_VALID;
    logic        Q_BP;
    logic        NFC_TVALID;
    logic [15:0] NFC_TDATA;
    logic        NFC_TREADY;
    logic [9:0]  LEVEL;
    logic        OVERFLOW;
    nfc_state_e  NFC_STATE;

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] exp_q[$];

    typedef struct {
        logic        vld;
        logic [63:0] data;
        logic        last;
        logic [9:0]  exp_level;
        logic        exp_qv;
    } vec_t;
    vec_t vecs[12];

    aurora_rx_nfc_buf dut (
        .CLK        (CLK),
        .SYS_RST    (SYS_RST),
        .CH_UP      (CH_UP),
        .RX_TDATA   (RX_TDATA),
        .RX_TVALID  (RX_TVALID),
        .RX_TLAST   (RX_TLAST),
        .Q          (Q),
        .Q_LAST     (Q_LAST),
        .Q_VALID    (Q_VALID),
        .Q_BP       (Q_BP),
        .NFC_TVALID (NFC_TVALID),
        .NFC_TDATA  (NFC_TDATA),
        .NFC_TREADY (NFC_TREADY),
        .LEVEL      (LEVEL),
        .OVERFLOW   (OVERFLOW),
        .NFC_STATE  (NFC_STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every downstream transfer must match the head of the expected queue.
    always @(negedge CLK) begin
        if (!SYS_RST && Q_VALID && !Q_BP) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_word", {Q_LAST, Q}, 65'h0);
                n_fail += (Q_LAST == 1'b0 && Q == 64'h0) ? 1 : 0;
            end else begin
                chk("sb_word", {Q_LAST, Q}, exp_q.pop_front());
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input logic l, input bit accept);
        RX_TVALID = 1'b1;
        RX_TDATA  = d;
        RX_TLAST  = l;
        if (accept) exp_q.push_back({l, d});
        @(posedge CLK);
        #1;
        RX_TVALID = 1'b0;
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) begin
            send_word({$urandom, $urandom}, ($urandom_range(0, 7) == 0), 1'b1);
        end
    endtask

    task automatic wait_level(input string name, input logic [9:0] lvl, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge CLK);
            if (LEVEL == lvl) hit = 1'b1;
        end
        chk(name, 65'(hit), 65'd1);
    endtask

    task automatic wait_drained(input string name, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge CLK);
            if (LEVEL == 10'd0 && !Q_VALID) hit = 1'b1;
        end
        chk(name, 65'(hit), 65'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_q"},          65'(Q),          65'd0);
        chk({tag, "_q_last"},     65'(Q_LAST),     65'd0);
        chk({tag, "_q_valid"},    65'(Q_VALID),    65'd0);
        chk({tag, "_nfc_tvalid"}, 65'(NFC_TVALID), 65'd0);
        chk({tag, "_nfc_tdata"},  65'(NFC_TDATA),  65'h0000);
        chk({tag, "_level"},      65'(LEVEL),      65'd0);
        chk({tag, "_overflow"},   65'(OVERFLOW),   65'd0);
        chk({tag, "_state"},      65'(NFC_STATE),  65'(XON_IDLE));
    endtask

    initial begin
        SYS_RST    = 1'b1;
        CH_UP      = 1'b1;
        RX_TDATA   = '0;
        RX_TVALID  = 1'b0;
        RX_TLAST   = 1'b0;
        Q_BP       = 1'b0;
        NFC_TREADY = 1'b0;

        // Ten back-to-back words, then two idle steps; level/valid observed after each edge.
        for (int i = 0; i < 12; i++) begin
            vecs[i].vld       = (i < 10);
            vecs[i].data      = 64'hA5A5_0000_0000_0000 + 64'(i * 16'h1111);
            vecs[i].last      = (i == 4) || (i == 9);
            vecs[i].exp_level = (i < 10) ? 10'd1 : 10'd0;
            vecs[i].exp_qv    = (i >= 1) && (i <= 10);
        end

        repeat (3) @(posedge CLK);
        #1;
        SYS_RST = 1'b0;
        @(negedge CLK);
        check_reset_values("reset");

        for (int i = 0; i < 12; i++) begin
            RX_TVALID = vecs[i].vld;
            RX_TDATA  = vecs[i].data;
            RX_TLAST  = vecs[i].last;
            if (vecs[i].vld) exp_q.push_back({vecs[i].last, vecs[i].data});
            @(posedge CLK);
            #1;
            RX_TVALID = 1'b0;
            @(negedge CLK);
            chk($sformatf("stream_level_%0d", i),  65'(LEVEL),   65'(vecs[i].exp_level));
            chk($sformatf("stream_qvalid_%0d", i), 65'(Q_VALID), 65'(vecs[i].exp_qv));
        end
        chk("stream_sb_empty", 65'(exp_q.size()), 65'd0);

        // XOFF at the high watermark, with the core slow to accept.
        @(posedge CLK);
        #1;
        Q_BP = 1'b1;
        send_random(449);
        @(negedge CLK);
        chk("hi_level",          65'(LEVEL),      65'd448);
        chk("hi_tvalid_not_yet", 65'(NFC_TVALID), 65'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("xoff_tvalid_%0d", i), 65'(NFC_TVALID), 65'd1);
            chk($sformatf("xoff_tdata_%0d", i),  65'(NFC_TDATA),  65'h0100);
        end
        @(posedge CLK);
        #1;
        NFC_TREADY = 1'b1;
        @(negedge CLK);
        chk("xoff_tvalid_at_ready", 65'(NFC_TVALID), 65'd1);
        @(posedge CLK);
        #1;
        NFC_TREADY = 1'b0;
        @(negedge CLK);
        chk("xoff_done_tvalid", 65'(NFC_TVALID), 65'd0);
        chk("xoff_done_tdata",  65'(NFC_TDATA),  65'h0100);
        chk("xoff_done_state",  65'(NFC_STATE),  65'(XOFF_HELD));

        // Drain to the low watermark; XON goes out and completes.
        @(posedge CLK);
        #1;
        Q_BP = 1'b0;
        wait_level("wait_lo_wm", 10'd128, 1000);
        chk("lo_state_held", 65'(NFC_STATE),  65'(XOFF_HELD));
        chk("lo_tvalid",     65'(NFC_TVALID), 65'd0);
        @(negedge CLK);
        chk("xon_tvalid", 65'(NFC_TVALID), 65'd1);
        chk("xon_tdata",  65'(NFC_TDATA),  65'h0000);
        @(posedge CLK);
        #1;
        NFC_TREADY = 1'b1;
        @(posedge CLK);
        #1;
        NFC_TREADY = 1'b0;
        @(negedge CLK);
        chk("xon_done_state",  65'(NFC_STATE),  65'(XON_IDLE));
        chk("xon_done_tvalid", 65'(NFC_TVALID), 65'd0);
        chk("xon_done_tdata",  65'(NFC_TDATA),  65'h0000);
        wait_drained("nfc_drain", 1000);
        chk("nfc_sb_empty", 65'(exp_q.size()), 65'd0);

        // Overflow: 513 words fill storage plus the output register, 3 more are dropped.
        @(posedge CLK);
        #1;
        Q_BP       = 1'b1;
        NFC_TREADY = 1'b1;
        send_random(513);
        @(negedge CLK);
        chk("full_level",    65'(LEVEL),    65'd512);
        chk("full_overflow", 65'(OVERFLOW), 65'd0);
        for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1'b0, 1'b0);
        @(negedge CLK);
        chk("drop_level",    65'(LEVEL),    65'd512);
        chk("drop_overflow", 65'(OVERFLOW), 65'd1);
        @(posedge CLK);
        #1;
        Q_BP = 1'b0;
        send_word(64'hFEED_FACE_0000_0512, 1'b1, 1'b1);
        Q_BP = 1'b1;
        @(negedge CLK);
        chk("full_wr_pop_level", 65'(LEVEL), 65'd512);
        @(posedge CLK);
        #1;
        Q_BP = 1'b0;
        wait_drained("ovf_drain", 2000);
        chk("ovf_sb_empty",      65'(exp_q.size()), 65'd0);
        chk("ovf_sticky",        65'(OVERFLOW),     65'd1);
        chk("ovf_state_idle",    65'(NFC_STATE),    65'(XON_IDLE));

        // Channel down mid-XOFF with 300 words stored.
        @(posedge CLK);
        #1;
        Q_BP       = 1'b1;
        NFC_TREADY = 1'b0;
        send_random(449);
        @(negedge CLK);
        @(negedge CLK);
        chk("chdn_pre_state", 65'(NFC_STATE), 65'(SEND_XOFF));
        @(posedge CLK);
        #1;
        Q_BP = 1'b0;
        repeat (148) @(posedge CLK);
        #1;
        Q_BP = 1'b1;
        @(negedge CLK);
        chk("chdn_pre_level",  65'(LEVEL),      65'd300);
        chk("chdn_held_req",   65'(NFC_TVALID), 65'd1);
        chk("chdn_held_tdata", 65'(NFC_TDATA),  65'h0100);
        @(posedge CLK);
        #1;
        CH_UP = 1'b0;
        send_word(64'h0BAD_0BAD_0BAD_0BAD, 1'b0, 1'b0);
        CH_UP = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        chk("chdn_level",    65'(LEVEL),      65'd0);
        chk("chdn_qvalid",   65'(Q_VALID),    65'd0);
        chk("chdn_tvalid",   65'(NFC_TVALID), 65'd0);
        chk("chdn_state",    65'(NFC_STATE),  65'(XON_IDLE));
        chk("chdn_overflow", 65'(OVERFLOW),   65'd1);

        // Reset in the middle of a flowing stream.
        @(posedge CLK);
        #1;
        Q_BP = 1'b0;
        send_random(8);
        SYS_RST = 1'b1;
        send_word(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        SYS_RST = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        check_reset_values("midrst");
        repeat (4) @(negedge CLK);
        chk("final_sb_empty", 65'(exp_q.size()), 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
